// File: rtl/display_frame_sequencer.sv
// Frame scheduler feeding the 5x7 column-scan displayer: stores up to DEPTH
// frames, then plays them with a programmable hold time and blanking gaps.
module display_frame_sequencer #(
  parameter int DATA_WIDTH   = 35,
  parameter int DEPTH        = 4,
  parameter int HOLD_WIDTH   = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
  input  logic [HOLD_WIDTH-1:0]        hold_cycles,
  output logic [DATA_WIDTH-1:0]        image,
  output logic                         display_enable,
  output logic [$clog2(DEPTH)-1:0]     frame_index,
  output logic [$clog2(DEPTH):0]       frame_count,
  output logic                         busy,
  output logic                         seq_done
);

  // state | meaning
  // IDLE  | store writable, image=0, waiting for start
  // SHOW  | current frame on image with display_enable high for the hold time
  // BLANK | display_enable low for BLANK_CYCLES, then next frame / wrap / end
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam int IW = $clog2(DEPTH);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);
  localparam logic [IW:0]   DEPTH_C    = (IW+1)'(DEPTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] store [DEPTH];
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic [BW-1:0]         blank_cnt;
  logic                  wr_fire;
  logic                  last_frame;
  logic [IW-1:0]         next_index;

  assign wr_ready   = (state == IDLE) && (frame_count < DEPTH_C) && !clear;
  assign wr_fire    = wr_valid && wr_ready;
  assign last_frame = ({1'b0, frame_index} == (frame_count - (IW+1)'(1)));
  assign next_index = last_frame ? '0 : frame_index + 1'b1;

  // Store has no reset: contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_fire) store[frame_count[IW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      frame_count    <= '0;
      frame_index    <= '0;
      hold_cnt       <= '0;
      blank_cnt      <= '0;
      image          <= '0;
      display_enable <= 1'b0;
      busy           <= 1'b0;
      seq_done       <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (stop && state != IDLE) begin
        state          <= IDLE;
        image          <= '0;
        display_enable <= 1'b0;
        busy           <= 1'b0;
        seq_done       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (clear)        frame_count <= '0;
            else if (wr_fire) frame_count <= frame_count + 1'b1;
            if (start && frame_count != '0 && !clear) begin
              state          <= SHOW;
              frame_index    <= '0;
              hold_cnt       <= hold_cycles;
              image          <= store[0];
              display_enable <= 1'b1;
              busy           <= 1'b1;
            end
          end
          SHOW: begin
            // hold of 0 or 1 both end the frame after a single clock
            if (hold_cnt[HOLD_WIDTH-1:1] == '0) begin
              state          <= BLANK;
              display_enable <= 1'b0;
              blank_cnt      <= BLANK_LOAD;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          BLANK: begin
            if (blank_cnt != '0) begin
              blank_cnt <= blank_cnt - 1'b1;
            end else if (!last_frame || loop_en) begin
              state          <= SHOW;
              frame_index    <= next_index;
              image          <= store[next_index];
              hold_cnt       <= hold_cycles;
              display_enable <= 1'b1;
            end else begin
              state    <= IDLE;
              image    <= '0;
              busy     <= 1'b0;
              seq_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Directed bench for display_frame_sequencer: a vector table for store fill and
// a single playback pass, plus hand sequences for loop, hold=0, stop and reset.
module tb_display_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [34:0] wr_data;
  logic        wr_ready;
  logic        clear, start, stop, loop_en;
  logic [15:0] hold_cycles;
  logic [34:0] image;
  logic        display_enable;
  logic [1:0]  frame_index;
  logic [2:0]  frame_count;
  logic        busy, seq_done;

  int checks = 0;
  int errors = 0;

  localparam logic [34:0] FA = 35'h1_1111_1111;
  localparam logic [34:0] FB = 35'h2_2222_2222;
  localparam logic [34:0] FC = 35'h3_3333_3333;
  localparam logic [34:0] FD = 35'h4_4444_4444;
  localparam logic [34:0] FE = 35'h5_5555_5555;

  display_frame_sequencer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear(clear), .start(start), .stop(stop),
    .loop_en(loop_en), .hold_cycles(hold_cycles), .image(image),
    .display_enable(display_enable), .frame_index(frame_index),
    .frame_count(frame_count), .busy(busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [34:0] wd;
    logic        clr, st, sp;
    logic [15:0] hold;
    logic        rdy, en;
    logic [34:0] img;
    logic [1:0]  idx;
    logic [2:0]  cnt;
    logic        bsy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wv, logic [34:0] wd, logic clr, logic st, logic sp,
                              logic [15:0] hold, logic rdy, logic en, logic [34:0] img,
                              logic [1:0] idx, logic [2:0] cnt, logic bsy, logic done);
    vec_t v;
    v.wv = wv; v.wd = wd; v.clr = clr; v.st = st; v.sp = sp; v.hold = hold;
    v.rdy = rdy; v.en = en; v.img = img; v.idx = idx; v.cnt = cnt; v.bsy = bsy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input string nm, input logic en, input logic [34:0] img,
                             input logic [1:0] idx, input logic bsy, input logic done);
    step();
    chk({nm, " en"},   64'(display_enable), 64'(en));
    chk({nm, " img"},  64'(image),          64'(img));
    chk({nm, " idx"},  64'(frame_index),    64'(idx));
    chk({nm, " busy"}, 64'(busy),           64'(bsy));
    chk({nm, " done"}, 64'(seq_done),       64'(done));
  endtask

  task automatic load2();
    clear = 1'b1; step(); clear = 1'b0;
    wr_valid = 1'b1; wr_data = FA; step();
    wr_data = FB; step();
    wr_valid = 1'b0;
    chk("load2 cnt", 64'(frame_count), 64'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0;
    stop = 1'b0; loop_en = 1'b0; hold_cycles = 16'd3;
    step(); step();
    chk("rst en",   64'(display_enable), 64'd0);
    chk("rst img",  64'(image),          64'd0);
    chk("rst idx",  64'(frame_index),    64'd0);
    chk("rst cnt",  64'(frame_count),    64'd0);
    chk("rst busy", 64'(busy),           64'd0);
    chk("rst done", 64'(seq_done),       64'd0);
    reset = 1'b1;
    step();

    //              wv  data clr st sp hold   rdy en img idx cnt bsy done
    vecs.push_back(mk(1, FA, 0, 0, 0, 16'd3, 1, 0, '0, 0, 1, 0, 0));
    vecs.push_back(mk(1, FB, 0, 0, 0, 16'd3, 1, 0, '0, 0, 2, 0, 0));
    vecs.push_back(mk(1, FC, 0, 0, 0, 16'd3, 1, 0, '0, 0, 3, 0, 0));
    vecs.push_back(mk(1, FD, 0, 0, 0, 16'd3, 0, 0, '0, 0, 4, 0, 0));
    vecs.push_back(mk(1, FE, 0, 0, 0, 16'd3, 0, 0, '0, 0, 4, 0, 0));
    vecs.push_back(mk(0, '0, 0, 0, 1, 16'd3, 0, 0, '0, 0, 4, 0, 0));
    vecs.push_back(mk(0, '0, 1, 0, 0, 16'd3, 0, 0, '0, 0, 0, 0, 0));
    vecs.push_back(mk(0, '0, 0, 1, 0, 16'd3, 1, 0, '0, 0, 0, 0, 0));
    vecs.push_back(mk(1, FD, 1, 0, 0, 16'd3, 0, 0, '0, 0, 0, 0, 0));
    vecs.push_back(mk(1, FA, 0, 0, 0, 16'd3, 1, 0, '0, 0, 1, 0, 0));
    vecs.push_back(mk(1, FB, 0, 0, 0, 16'd3, 1, 0, '0, 0, 2, 0, 0));
    vecs.push_back(mk(1, FC, 0, 0, 0, 16'd3, 1, 0, '0, 0, 3, 0, 0));
    vecs.push_back(mk(0, '0, 0, 1, 1, 16'd3, 0, 1, FA, 0, 3, 1, 0));
    vecs.push_back(mk(1, FE, 0, 0, 0, 16'd3, 0, 1, FA, 0, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 1, FA, 0, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 0, FA, 0, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 0, FA, 0, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 1, FB, 1, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 1, FB, 1, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 1, FB, 1, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 0, FB, 1, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 0, FB, 1, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 1, FC, 2, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 1, FC, 2, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 1, FC, 2, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 0, FC, 2, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 0, 0, FC, 2, 3, 1, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 1, 0, '0, 2, 3, 0, 1));
    vecs.push_back(mk(0, '0, 0, 0, 0, 16'd3, 1, 0, '0, 2, 3, 0, 0));

    foreach (vecs[i]) begin
      wr_valid = vecs[i].wv; wr_data = vecs[i].wd; clear = vecs[i].clr;
      start = vecs[i].st; stop = vecs[i].sp; hold_cycles = vecs[i].hold;
      step();
      chk($sformatf("v%0d rdy", i),  64'(wr_ready),       64'(vecs[i].rdy));
      chk($sformatf("v%0d en", i),   64'(display_enable), 64'(vecs[i].en));
      chk($sformatf("v%0d img", i),  64'(image),          64'(vecs[i].img));
      chk($sformatf("v%0d idx", i),  64'(frame_index),    64'(vecs[i].idx));
      chk($sformatf("v%0d cnt", i),  64'(frame_count),    64'(vecs[i].cnt));
      chk($sformatf("v%0d busy", i), 64'(busy),           64'(vecs[i].bsy));
      chk($sformatf("v%0d done", i), 64'(seq_done),       64'(vecs[i].done));
    end
    wr_valid = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;

    // looping two frames, loop_en dropped during the second B hold
    load2();
    hold_cycles = 16'd2; loop_en = 1'b1; start = 1'b1;
    expect_step("lp0", 1, FA, 0, 1, 0); start = 1'b0;
    expect_step("lp1", 1, FA, 0, 1, 0);
    expect_step("lp2", 0, FA, 0, 1, 0);
    expect_step("lp3", 0, FA, 0, 1, 0);
    expect_step("lp4", 1, FB, 1, 1, 0);
    expect_step("lp5", 1, FB, 1, 1, 0);
    expect_step("lp6", 0, FB, 1, 1, 0);
    expect_step("lp7", 0, FB, 1, 1, 0);
    expect_step("lp8", 1, FA, 0, 1, 0);
    expect_step("lp9", 1, FA, 0, 1, 0);
    expect_step("lp10", 0, FA, 0, 1, 0);
    expect_step("lp11", 0, FA, 0, 1, 0);
    expect_step("lp12", 1, FB, 1, 1, 0);
    loop_en = 1'b0;
    expect_step("lp13", 1, FB, 1, 1, 0);
    expect_step("lp14", 0, FB, 1, 1, 0);
    expect_step("lp15", 0, FB, 1, 1, 0);
    expect_step("lp16", 0, '0, 1, 0, 1);
    expect_step("lp17", 0, '0, 1, 0, 0);

    // hold_cycles=0 behaves as a one-clock hold
    load2();
    hold_cycles = 16'd0; start = 1'b1;
    expect_step("h0", 1, FA, 0, 1, 0); start = 1'b0;
    expect_step("h1", 0, FA, 0, 1, 0);
    expect_step("h2", 0, FA, 0, 1, 0);
    expect_step("h3", 1, FB, 1, 1, 0);
    expect_step("h4", 0, FB, 1, 1, 0);
    expect_step("h5", 0, FB, 1, 1, 0);
    expect_step("h6", 0, '0, 1, 0, 1);
    expect_step("h7", 0, '0, 1, 0, 0);

    // stop during B, then restart from A
    hold_cycles = 16'd3; start = 1'b1;
    expect_step("s0", 1, FA, 0, 1, 0); start = 1'b0;
    expect_step("s1", 1, FA, 0, 1, 0);
    expect_step("s2", 1, FA, 0, 1, 0);
    expect_step("s3", 0, FA, 0, 1, 0);
    expect_step("s4", 0, FA, 0, 1, 0);
    expect_step("s5", 1, FB, 1, 1, 0);
    stop = 1'b1;
    expect_step("s6", 0, '0, 1, 0, 1); stop = 1'b0;
    expect_step("s7", 0, '0, 1, 0, 0);
    chk("s7 cnt", 64'(frame_count), 64'd2);
    start = 1'b1;
    expect_step("r0", 1, FA, 0, 1, 0); start = 1'b0;
    expect_step("r1", 1, FA, 0, 1, 0);

    // asynchronous reset between clock edges during SHOW
    #3 reset = 1'b0;
    #1;
    chk("ar en",   64'(display_enable), 64'd0);
    chk("ar img",  64'(image),          64'd0);
    chk("ar cnt",  64'(frame_count),    64'd0);
    chk("ar idx",  64'(frame_index),    64'd0);
    chk("ar busy", 64'(busy),           64'd0);
    chk("ar rdy",  64'(wr_ready),       64'd1);
    #2 reset = 1'b1;
    wr_valid = 1'b1; wr_data = FC;
    step();
    wr_valid = 1'b0;
    chk("ar wr cnt", 64'(frame_count), 64'd1);
    chk("ar wr busy", 64'(busy),       64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
